// File: rtl/srt_arb_pkg.sv
// Shared constants and helpers for the frame-RAM port arbiter.
package srt_arb_pkg;

    localparam int ARB_ADDR_W   = 16;
    localparam int ARB_DATA_W   = 32;
    localparam int STARVE_CNT_W = 8;

    // Width of a client id / round-robin pointer able to hold values up to n-1
    function automatic int id_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/ram_port_arbiter_rr_picker.sv
// rr_picker: rotating priority encoder over clients 1..N-1, purely combinational.
// Scans from ptr upward, wrapping N-1 -> 1; next_ptr is the winner + 1 (N wraps to 1).
module rr_picker
    import srt_arb_pkg::*;
#(
    parameter int NUM_CLIENTS = 4,
    localparam int PW = id_width(NUM_CLIENTS)
) (
    input  logic [NUM_CLIENTS-1:1] req,
    input  logic [PW-1:0]          ptr,
    output logic [NUM_CLIENTS-1:1] grant,
    output logic [PW-1:0]          next_ptr
);

    logic found;

    // Pass 0 covers ptr..N-1, pass 1 covers the wrapped part 1..ptr-1
    always_comb begin
        grant    = '0;
        next_ptr = ptr;
        found    = 1'b0;
        for (int p = 0; p < 2; p++) begin
            for (int i = 1; i < NUM_CLIENTS; i++) begin
                if (!found && req[i] && ((p == 0) == (i >= int'(ptr)))) begin
                    found    = 1'b1;
                    grant[i] = 1'b1;
                    next_ptr = (i == NUM_CLIENTS - 1) ? PW'(1) : PW'(i + 1);
                end
            end
        end
    end

endmodule

// File: rtl/ram_port_arbiter.sv
// N-client arbiter for the single-ported frame RAM: client 0 absolute priority,
// clients 1..N-1 round-robin. Optional starvation monitor under SRT_ARB_STARVE_EN.
module ram_port_arbiter
    import srt_arb_pkg::*;
#(
    parameter int NUM_CLIENTS      = 4,
    parameter int ADDR_WIDTH       = ARB_ADDR_W,
    parameter int DATA_WIDTH       = ARB_DATA_W,
    parameter int RAM_READ_LATENCY = 1,
    parameter int STARVE_LIMIT     = 255
) (
    input  logic                              clock,
    input  logic                              reset_n,
    input  logic [NUM_CLIENTS-1:0]            clientReq,
    input  logic [NUM_CLIENTS-1:0]            clientWrite,
    input  logic [NUM_CLIENTS*ADDR_WIDTH-1:0] clientAddr,
    input  logic [NUM_CLIENTS*DATA_WIDTH-1:0] clientWData,
    output logic [NUM_CLIENTS-1:0]            clientGrant,
    output logic [DATA_WIDTH-1:0]             rdData,
    output logic [NUM_CLIENTS-1:0]            rdValid,
    output logic [NUM_CLIENTS-1:0]            starved,
    input  logic                              starveClear,
    output logic [ADDR_WIDTH-1:0]             ramAddr,
    output logic [DATA_WIDTH-1:0]             ramDataWrite,
    output logic                              ramWriteEnable,
    input  logic [DATA_WIDTH-1:0]             ramDataRead
);

    localparam int PTR_W = id_width(NUM_CLIENTS);

    logic [PTR_W-1:0]       rr_ptr, rr_next;
    logic [NUM_CLIENTS-1:1] rr_grant;
    logic [ADDR_WIDTH-1:0]  sel_addr, addr_q;
    logic [DATA_WIDTH-1:0]  sel_wdata;
    logic                   sel_write;
    logic                   any_grant;
    logic [NUM_CLIENTS-1:0] rd_tag;
    logic [RAM_READ_LATENCY:1][NUM_CLIENTS-1:0] vld_pipe;

    rr_picker #(.NUM_CLIENTS(NUM_CLIENTS)) u_pick (
        .req      (clientReq[NUM_CLIENTS-1:1]),
        .ptr      (rr_ptr),
        .grant    (rr_grant),
        .next_ptr (rr_next)
    );

    // Grant is gated by reset so nothing reaches the RAM while held in reset
    always_comb begin
        clientGrant = '0;
        if (reset_n) begin
            if (clientReq[0]) clientGrant[0] = 1'b1;
            else              clientGrant[NUM_CLIENTS-1:1] = rr_grant;
        end
    end

    assign any_grant = |clientGrant;

    always_comb begin
        sel_addr  = '0;
        sel_wdata = '0;
        sel_write = 1'b0;
        for (int i = 0; i < NUM_CLIENTS; i++) begin
            if (clientGrant[i]) begin
                sel_addr  = clientAddr[i*ADDR_WIDTH +: ADDR_WIDTH];
                sel_wdata = clientWData[i*DATA_WIDTH +: DATA_WIDTH];
                sel_write = clientWrite[i];
            end
        end
    end

    // Idle cycles keep the last address on the bus
    assign ramAddr        = any_grant ? sel_addr : addr_q;
    assign ramDataWrite   = sel_wdata;
    assign ramWriteEnable = sel_write;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr <= PTR_W'(1);
            addr_q <= '0;
        end else begin
            addr_q <= ramAddr;
            if (!clientReq[0] && |rr_grant) rr_ptr <= rr_next;
        end
    end

    assign rd_tag = clientGrant & ~clientWrite;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            vld_pipe <= '0;
        end else begin
            vld_pipe[1] <= rd_tag;
            for (int s = 2; s <= RAM_READ_LATENCY; s++) vld_pipe[s] <= vld_pipe[s-1];
        end
    end

    assign rdValid = vld_pipe[RAM_READ_LATENCY];
    assign rdData  = ramDataRead;

`ifdef SRT_ARB_STARVE_EN
    localparam logic [STARVE_CNT_W-1:0] LIM = STARVE_CNT_W'(STARVE_LIMIT);

    assign starved[0] = 1'b0;

    for (genvar i = 1; i < NUM_CLIENTS; i++) begin : g_starve
        logic [STARVE_CNT_W-1:0] cnt, cnt_next;
        logic                    waiting, set_evt, flag;

        assign waiting = clientReq[i] && !clientGrant[i];

        always_comb begin
            cnt_next = '0;
            if (waiting) cnt_next = (cnt == LIM) ? cnt : cnt + 1'b1;
        end

        assign set_evt = waiting && (cnt_next == LIM);

        // Set beats a coincident clear
        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                cnt  <= '0;
                flag <= 1'b0;
            end else begin
                cnt  <= cnt_next;
                flag <= set_evt | (flag & ~starveClear);
            end
        end

        assign starved[i] = flag;
    end
`else
    logic unused_starve_clear;
    assign unused_starve_clear = starveClear;
    assign starved = '0;
`endif

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter: latency-1 instance with a RAM model plus a
// latency-3 instance for read-pipeline and mid-flight reset checks.
module tb_ram_port_arbiter;

    localparam int N  = 4;
    localparam int AW = 16;
    localparam int DW = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // latency-1 instance
    logic            rst_n, clr, ram_we;
    logic [N-1:0]    req, wr, grant, rd_valid, starved;
    logic [N*AW-1:0] addr;
    logic [N*DW-1:0] wdata;
    logic [DW-1:0]   rd_data, ram_wd, ram_rd;
    logic [AW-1:0]   ram_addr;

    ram_port_arbiter #(.NUM_CLIENTS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
                       .RAM_READ_LATENCY(1), .STARVE_LIMIT(10)) dut (
        .clock(clk), .reset_n(rst_n), .clientReq(req), .clientWrite(wr),
        .clientAddr(addr), .clientWData(wdata), .clientGrant(grant),
        .rdData(rd_data), .rdValid(rd_valid), .starved(starved), .starveClear(clr),
        .ramAddr(ram_addr), .ramDataWrite(ram_wd), .ramWriteEnable(ram_we),
        .ramDataRead(ram_rd)
    );

    logic [DW-1:0] mem [0:65535];
    initial for (int i = 0; i < 65536; i++) mem[i] = 32'hA000_0000 | i;
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_wd;
        ram_rd <= mem[ram_addr];
    end

    // latency-3 instance
    logic            rst3, clr3, ram_we3;
    logic [N-1:0]    req3, wr3, grant3, rd_valid3, starved3;
    logic [N*AW-1:0] addr3;
    logic [N*DW-1:0] wdata3;
    logic [DW-1:0]   rd_data3, ram_wd3, ram_rd3, r3a, r3b;
    logic [AW-1:0]   ram_addr3;

    ram_port_arbiter #(.NUM_CLIENTS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
                       .RAM_READ_LATENCY(3), .STARVE_LIMIT(10)) dut3 (
        .clock(clk), .reset_n(rst3), .clientReq(req3), .clientWrite(wr3),
        .clientAddr(addr3), .clientWData(wdata3), .clientGrant(grant3),
        .rdData(rd_data3), .rdValid(rd_valid3), .starved(starved3), .starveClear(clr3),
        .ramAddr(ram_addr3), .ramDataWrite(ram_wd3), .ramWriteEnable(ram_we3),
        .ramDataRead(ram_rd3)
    );

    always @(posedge clk) begin
        r3a     <= 32'hB000_0000 | {16'h0, ram_addr3};
        r3b     <= r3a;
        ram_rd3 <= r3b;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; req = '0; wr = '0; clr = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req = 4'b1111; wr = '0; clr = 1'b0;
        #2;
        tests++; if (grant !== 4'b0000) begin fails++; $display("FAIL reset_grant got %b want 0000", grant); end
        tests++; if (ram_addr !== 16'h0000) begin fails++; $display("FAIL reset_addr got %h want 0000", ram_addr); end
        tests++; if (rd_valid !== 4'b0000) begin fails++; $display("FAIL reset_rdvalid got %b want 0000", rd_valid); end
        tests++; if (starved !== 4'b0000) begin fails++; $display("FAIL reset_starved got %b want 0000", starved); end
        tests++; if (ram_we !== 1'b0) begin fails++; $display("FAIL reset_we got %b want 0", ram_we); end
    endtask

    task automatic test_round_robin();
        logic [N-1:0] exp_g, prev_g;
        int           idx, prev_idx;
        do_reset();
        prev_g = '0; prev_idx = 0;
        for (int k = 0; k < 6; k++) begin
            tick();
            req = 4'b1110; wr = '0;
            #1;
            idx   = (k % 3) + 1;
            exp_g = 4'(1 << idx);
            tests++; if (grant !== exp_g) begin fails++; $display("FAIL rr_grant cyc %0d got %b want %b", k, grant, exp_g); end
            tests++; if (ram_addr !== 16'(16 * idx)) begin fails++; $display("FAIL rr_addr cyc %0d got %h want %h", k, ram_addr, 16'(16 * idx)); end
            tests++; if (rd_valid !== prev_g) begin fails++; $display("FAIL rr_rdvalid cyc %0d got %b want %b", k, rd_valid, prev_g); end
            if (k > 0) begin
                tests++;
                if (rd_data !== (32'hA000_0000 | 32'(16 * prev_idx))) begin
                    fails++; $display("FAIL rr_rddata cyc %0d got %h want %h", k, rd_data, 32'hA000_0000 | 32'(16 * prev_idx));
                end
            end
            prev_g = exp_g; prev_idx = idx;
        end
    endtask

    task automatic test_priority();
        logic [N-1:0] preq [6];
        logic [N-1:0] pexp [6];
        preq = '{4'b0110, 4'b0111, 4'b0111, 4'b0111, 4'b0110, 4'b0110};
        pexp = '{4'b0010, 4'b0001, 4'b0001, 4'b0001, 4'b0100, 4'b0010};
        do_reset();
        for (int k = 0; k < 6; k++) begin
            tick();
            req = preq[k]; wr = '0;
            #1;
            tests++; if (grant !== pexp[k]) begin fails++; $display("FAIL prio_grant cyc %0d got %b want %b", k + 1, grant, pexp[k]); end
        end
    endtask

    task automatic test_write_read();
        do_reset();
        addr[2*AW +: AW]  = 16'h0040;
        wdata[2*DW +: DW] = 32'hDEAD_BEEF;
        tick();
        req = 4'b0100; wr = 4'b0100;
        #1;
        tests++; if (grant !== 4'b0100) begin fails++; $display("FAIL wr_grant got %b want 0100", grant); end
        tests++; if (ram_we !== 1'b1) begin fails++; $display("FAIL wr_we got %b want 1", ram_we); end
        tests++; if (ram_addr !== 16'h0040) begin fails++; $display("FAIL wr_addr got %h want 0040", ram_addr); end
        tests++; if (ram_wd !== 32'hDEAD_BEEF) begin fails++; $display("FAIL wr_data got %h want deadbeef", ram_wd); end
        tick();
        req = '0; wr = '0;
        #1;
        tests++; if (ram_we !== 1'b0) begin fails++; $display("FAIL wr_we_drop got %b want 0", ram_we); end
        tests++; if (ram_addr !== 16'h0040) begin fails++; $display("FAIL idle_addr_hold got %h want 0040", ram_addr); end
        tests++; if (rd_valid !== 4'b0000) begin fails++; $display("FAIL wr_no_rdvalid got %b want 0000", rd_valid); end
        tick();
        req = 4'b0100; wr = '0;
        #1;
        tests++; if (grant !== 4'b0100) begin fails++; $display("FAIL rd_grant got %b want 0100", grant); end
        tick();
        req = '0;
        #1;
        tests++; if (rd_valid !== 4'b0100) begin fails++; $display("FAIL rd_valid got %b want 0100", rd_valid); end
        tests++; if (rd_data !== 32'hDEAD_BEEF) begin fails++; $display("FAIL rd_data got %h want deadbeef", rd_data); end
        addr[2*AW +: AW]  = 16'h0020;
        wdata[2*DW +: DW] = '0;
    endtask

    task automatic test_latency3();
        logic [N-1:0] exp_v [6];
        exp_v = '{4'b0000, 4'b0000, 4'b0000, 4'b0010, 4'b0100, 4'b0000};
        rst3 = 1'b0; req3 = '0; wr3 = '0; clr3 = 1'b0;
        tick();
        rst3 = 1'b1;
        // cycle t: grant 1, t+1: grant 2, then idle
        for (int k = 0; k < 6; k++) begin
            tick();
            req3 = (k == 0) ? 4'b0110 : (k == 1) ? 4'b0100 : 4'b0000;
            #1;
            if (k == 0) begin tests++; if (grant3 !== 4'b0010) begin fails++; $display("FAIL l3_grant t got %b want 0010", grant3); end end
            if (k == 1) begin tests++; if (grant3 !== 4'b0100) begin fails++; $display("FAIL l3_grant t+1 got %b want 0100", grant3); end end
            tests++; if (rd_valid3 !== exp_v[k]) begin fails++; $display("FAIL l3_rdvalid t+%0d got %b want %b", k, rd_valid3, exp_v[k]); end
            if (k == 3) begin tests++; if (rd_data3 !== 32'hB000_0010) begin fails++; $display("FAIL l3_rddata t+3 got %h want b0000010", rd_data3); end end
            if (k == 4) begin tests++; if (rd_data3 !== 32'hB000_0020) begin fails++; $display("FAIL l3_rddata t+4 got %h want b0000020", rd_data3); end end
        end
        // Same pair of reads, reset lands at t+2 while both tags are in flight
        for (int k = 0; k < 5; k++) begin
            tick();
            req3 = (k == 0) ? 4'b0110 : (k == 1) ? 4'b0100 : (k == 3) ? 4'b0010 : 4'b0000;
            #1;
            if (k == 2) rst3 = 1'b0;
            if (k >= 3) begin
                tests++; if (rd_valid3 !== 4'b0000) begin fails++; $display("FAIL l3_rst_drop t+%0d got %b want 0000", k, rd_valid3); end
            end
            if (k == 3) begin tests++; if (grant3 !== 4'b0000) begin fails++; $display("FAIL l3_rst_grant got %b want 0000", grant3); end end
        end
        rst3 = 1'b1; req3 = '0;
    endtask

    task automatic test_starve();
        logic [N-1:0] exp_s;
        do_reset();
        for (int c = 1; c <= 14; c++) begin
            tick();
            req = 4'b0011; wr = '0;
            #1;
`ifdef SRT_ARB_STARVE_EN
            exp_s = (c >= 11) ? 4'b0010 : 4'b0000;
`else
            exp_s = 4'b0000;
`endif
            tests++; if (grant !== 4'b0001) begin fails++; $display("FAIL starve_grant cyc %0d got %b want 0001", c, grant); end
            tests++; if (starved !== exp_s) begin fails++; $display("FAIL starve_flag cyc %0d got %b want %b", c, starved, exp_s); end
        end
        tick();
        req = '0; clr = 1'b1;
        #1;
`ifdef SRT_ARB_STARVE_EN
        exp_s = 4'b0010;
`else
        exp_s = 4'b0000;
`endif
        tests++; if (starved !== exp_s) begin fails++; $display("FAIL starve_sticky got %b want %b", starved, exp_s); end
        tick();
        clr = 1'b0;
        #1;
        tests++; if (starved !== 4'b0000) begin fails++; $display("FAIL starve_clear got %b want 0000", starved); end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        addr  = {16'h0030, 16'h0020, 16'h0010, 16'h0000};
        wdata = '0;
        addr3 = {16'h0030, 16'h0020, 16'h0010, 16'h0000};
        wdata3 = '0;
        rst3 = 1'b0; req3 = '0; wr3 = '0; clr3 = 1'b0;
        test_reset();
        test_round_robin();
        test_priority();
        test_write_read();
        test_latency3();
        test_starve();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
